multiport_memory_controller: RTL

Parametrised line-granular main-memory model and arbiter serving NUM_PORTS cache clients (port 0 = data cache, port 1 = instruction cache in the default core build). It generalises the two-client controller: any number of ports, configurable line width, depth and access latency, one outstanding transaction at a time, and fair arbitration. It sits between the cache layer and the (modelled) DRAM and is instantiated by the cache test tops and the core top.

---
 rtl/multiport_memory_controller.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multiport_memory_controller.sv
// -----------------------------------------------------------------------------
// multiport_memory_controller
//
// Line-granular main-memory model plus arbiter serving NUM_PORTS cache clients.
// One transaction is in flight at a time. A granted request is latched
// (port, direction, address, write line), held for MEM_LATENCY busy cycles,
// and then answered with a single-cycle one-hot pulse on the granted port.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration. The search starts one past the last
//               granted port. The pointer resets to NUM_PORTS-1, so port 0
//               wins first after reset.
//   undefined : fixed priority. The lowest-numbered requesting port wins.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   asynchronous, active-high reset
//   req               in   [NUM_PORTS]            per-port request level, held until acked
//   req_write         in   [NUM_PORTS]            1 = line write, 0 = line read
//   req_addr          in   [NUM_PORTS*ADDR_WIDTH] port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_from_cache   in   [NUM_PORTS*LINE_WIDTH] per-port write line
//   data_to_cache     out  [LINE_WIDTH]           shared read line, held until next read
//   read_ready        out  [NUM_PORTS]            one-hot 1-cycle pulse, read data valid
//   written_data_ack  out  [NUM_PORTS]            one-hot 1-cycle pulse, write committed
//   busy              out                         transaction in flight
//   grant_id          out  [GID_W]                port currently / last served
// -----------------------------------------------------------------------------
module multiport_memory_controller #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 26,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LOG2  = 10,
  parameter int MEM_LATENCY = 4,
  localparam int GID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] data_from_cache,
  output logic [LINE_WIDTH-1:0]           data_to_cache,
  output logic [NUM_PORTS-1:0]            read_ready,
  output logic [NUM_PORTS-1:0]            written_data_ack,
  output logic                            busy,
  output logic [GID_W-1:0]                grant_id
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int LINES = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Arbitration functions
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  function automatic logic [GID_W-1:0] f_rr_pick(
    input logic [NUM_PORTS-1:0] reqs,
    input logic [GID_W-1:0]     last
  );
    logic [GID_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(last) + 1 + k) % NUM_PORTS;
      if (!found && reqs[idx]) begin
        found = 1'b1;
        pick  = GID_W'(idx);
      end
    end
    return pick;
  endfunction
`else
  function automatic logic [GID_W-1:0] f_fixed_pick(
    input logic [NUM_PORTS-1:0] reqs
  );
    logic [GID_W-1:0] pick;
    pick = '0;
    // Walk downwards so the lowest requesting index is the last one written.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (reqs[k]) begin
        pick = GID_W'(k);
      end
    end
    return pick;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [GID_W-1:0]       r_port;
  logic                   r_wr;
  logic [DEPTH_LOG2-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_wdata;
  logic [LINE_WIDTH-1:0]  r_rdata;
  logic [NUM_PORTS-1:0]   r_rd_rdy;
  logic [NUM_PORTS-1:0]   r_wr_ack;
  logic                   r_busy;
  logic [GID_W-1:0]       r_gid;
`ifdef ARB_ROUND_ROBIN_EN
  logic [GID_W-1:0]       r_ptr;
`endif

  // Storage is never reset; contents are undefined until written.
  logic [LINE_WIDTH-1:0]  r_mem [LINES];

  // ---------------------------------------------------------------------------
  // Combinational arbitration and request selection
  // ---------------------------------------------------------------------------
  logic                   w_any;
  logic [GID_W-1:0]       w_gnt;
  logic [ADDR_WIDTH-1:0]  w_addr_sel;
  logic [LINE_WIDTH-1:0]  w_wdata_sel;
  logic                   w_grant;
  logic                   w_done;
  logic                   w_mem_we;
  logic                   w_unused_addr_hi;

  assign w_any = |req;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_gnt = f_rr_pick(req, r_ptr);
`else
  assign w_gnt = f_fixed_pick(req);
`endif

  assign w_addr_sel  = req_addr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata_sel = data_from_cache[int'(w_gnt)*LINE_WIDTH +: LINE_WIDTH];

  // Upper address bits only alias onto the stored lines; they carry no state.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
      assign w_unused_addr_hi = ^w_addr_sel[ADDR_WIDTH-1:DEPTH_LOG2];
    end else begin : g_no_addr_hi
      assign w_unused_addr_hi = 1'b0;
    end
  endgenerate

  assign w_grant  = (r_state == S_IDLE) && w_any;
  assign w_done   = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_mem_we = w_done && r_wr && !reset;

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> BUSY (MEM_LATENCY cycles) -> RESP -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_port   <= '0;
      r_wr     <= 1'b0;
      r_rdata  <= '0;
      r_rd_rdy <= '0;
      r_wr_ack <= '0;
      r_busy   <= 1'b0;
      r_gid    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr    <= GID_W'(NUM_PORTS - 1);
`endif
    end else begin
      // Response pulses are single-cycle by default.
      r_rd_rdy <= '0;
      r_wr_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_W'(MEM_LATENCY - 1);
            r_port  <= w_gnt;
            r_wr    <= req_write[w_gnt];
            r_busy  <= 1'b1;
            r_gid   <= w_gnt;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= w_gnt;
`endif
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            if (r_wr) begin
              r_wr_ack <= NUM_PORTS'(1) << r_port;
            end else begin
              r_rd_rdy <= NUM_PORTS'(1) << r_port;
              r_rdata  <= r_mem[r_addr];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Latched request payload and line storage (no reset on data)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_grant && !reset) begin
      r_addr  <= w_addr_sel[DEPTH_LOG2-1:0];
      r_wdata <= w_wdata_sel;
    end
    // A write is committed only on the BUSY->RESP edge, so an abort by reset
    // before that edge leaves storage untouched.
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign data_to_cache    = r_rdata;
  assign read_ready       = r_rd_rdy;
  assign written_data_ack = r_wr_ack;
  assign busy             = r_busy;
  assign grant_id         = r_gid;

endmodule
